// File: rtl/int_ctrl_if.sv
// Bus between the CPU core and the interrupt/exception controller.
// The CPU side drives the instruction fields, status and eret; the controller
// side returns the redirect pulse, cause, line index, EPC and pending state.
interface int_ctrl_if #(
    parameter int N_IRQ   = 4,
    parameter int PC_W    = 32,
    parameter int CAUSE_W = 4
);
    logic [N_IRQ-1:0]   irq;
    logic [5:0]         op;
    logic [5:0]         funct;
    logic [31:0]        sta;
    logic [PC_W-1:0]    pc_in;
    logic               eret;
    logic               inta;
    logic               pcint;
    logic [CAUSE_W-1:0] cause;
    logic [2:0]         irq_id;
    logic [PC_W-1:0]    epc;
    logic [N_IRQ-1:0]   pending;

    // Controller side
    modport slave (
        input  irq, op, funct, sta, pc_in, eret,
        output inta, pcint, cause, irq_id, epc, pending
    );

    // CPU side
    modport master (
        output irq, op, funct, sta, pc_in, eret,
        input  inta, pcint, cause, irq_id, epc, pending
    );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt/exception controller for the multi-cycle MIPS CPU.
// Syscall/break are decoded from op/funct; external lines are rising-edge
// detected into sticky pending bits. One event is taken at a time by fixed
// priority; the controller stays in service (no nesting) until eret.
module int_ctrl #(
    parameter int N_IRQ   = 4,
    parameter int PC_W    = 32,
    parameter int CAUSE_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    int_ctrl_if.slave  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_SVC = 1'b1
    } state_t;

    state_t             state_q;
    logic               inta_q;
    logic               pcint_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [2:0]         irq_id_q;
    logic [PC_W-1:0]    epc_q;
    logic [N_IRQ-1:0]   irq_d_q;
    logic [N_IRQ-1:0]   pending_q;
    logic [N_IRQ-1:0]   pending_d;

    logic [N_IRQ-1:0]   irq_edge;
    logic [N_IRQ-1:0]   ext_req;
    logic [N_IRQ-1:0]   clr_w;
    logic               sys_req;
    logic               brk_req;
    logic               ext_any;
    logic               take;
    logic               take_ext;
    logic [2:0]         win_idx;
    logic [CAUSE_W-1:0] win_cause;

    // Status bits that this controller does not interpret
    logic sta_unused;
    assign sta_unused = ^{bus.sta[31:8+N_IRQ], bus.sta[7:3]};

    // Synchronous exceptions carry their own enables; global IE does not gate them
    assign sys_req = (bus.op == 6'h00) && (bus.funct == 6'h0C) && bus.sta[1];
    assign brk_req = (bus.op == 6'h00) && (bus.funct == 6'h0D) && bus.sta[2];

    // Per-line edge detect, eligibility and take-clear decode
    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_line
            assign irq_edge[gi] = bus.irq[gi] & ~irq_d_q[gi];
            assign ext_req[gi]  = pending_q[gi] & bus.sta[8+gi] & bus.sta[0];
            assign clr_w[gi]    = take_ext && (win_idx == 3'(gi));
        end
    endgenerate

    // Lowest-numbered eligible line wins among external requests
    always_comb begin
        win_idx = 3'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (ext_req[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    assign ext_any  = |ext_req;
    assign take     = (state_q == IDLE) && (sys_req || brk_req || ext_any);
    assign take_ext = (state_q == IDLE) && !sys_req && !brk_req && ext_any;

    assign win_cause = sys_req ? CAUSE_W'(4'b0100) :
                       brk_req ? CAUSE_W'(4'b1000) : CAUSE_W'(4'b0000);

    // A fresh edge on the line being taken keeps it pending (set beats clear)
    assign pending_d = irq_edge | (pending_q & ~clr_w);

    // Edge history starts all ones so lines high at reset release are not edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_d_q   <= '1;
            pending_q <= '0;
        end else begin
            irq_d_q   <= bus.irq;
            pending_q <= pending_d;
        end
    end

    // Service FSM with registered outputs; pcint is a single-cycle strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            inta_q   <= 1'b0;
            pcint_q  <= 1'b0;
            cause_q  <= '0;
            irq_id_q <= 3'd0;
            epc_q    <= '0;
        end else begin
            pcint_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q  <= IN_SVC;
                        inta_q   <= 1'b1;
                        pcint_q  <= 1'b1;
                        epc_q    <= bus.pc_in;
                        cause_q  <= win_cause;
                        irq_id_q <= (sys_req || brk_req) ? 3'd0 : win_idx;
                    end
                end
                IN_SVC: begin
                    if (bus.eret) begin
                        state_q <= IDLE;
                        inta_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.inta    = inta_q;
    assign bus.pcint   = pcint_q;
    assign bus.cause   = cause_q;
    assign bus.irq_id  = irq_id_q;
    assign bus.epc     = epc_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl: one task per scenario, inline checks,
// outputs sampled 1 ns after the rising edge.
module tb_int_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int_ctrl_if #(.N_IRQ(4), .PC_W(32), .CAUSE_W(4)) bus ();

    int_ctrl #(.N_IRQ(4), .PC_W(32), .CAUSE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic finish_service();
        bus.eret = 1'b1;
        step();
        bus.eret = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.irq = 4'hF; bus.op = 6'h00; bus.funct = 6'h00;
        bus.sta = 32'h0000_0F01; bus.pc_in = 32'h0; bus.eret = 1'b0;
        step(2);
        checks++; if (bus.inta !== 1'b0) begin failures++; $display("FAIL rst_inta got=%0h exp=0", bus.inta); end
        checks++; if (bus.pcint !== 1'b0) begin failures++; $display("FAIL rst_pcint got=%0h exp=0", bus.pcint); end
        checks++; if (bus.cause !== 4'h0) begin failures++; $display("FAIL rst_cause got=%0h exp=0", bus.cause); end
        checks++; if (bus.irq_id !== 3'd0) begin failures++; $display("FAIL rst_irq_id got=%0h exp=0", bus.irq_id); end
        checks++; if (bus.epc !== 32'h0) begin failures++; $display("FAIL rst_epc got=%0h exp=0", bus.epc); end
        checks++; if (bus.pending !== 4'h0) begin failures++; $display("FAIL rst_pending got=%0h exp=0", bus.pending); end
        // lines held high across reset release must not register as edges
        rst = 1'b0;
        step(2);
        checks++; if (bus.pending !== 4'h0) begin failures++; $display("FAIL rel_pending got=%0h exp=0", bus.pending); end
        checks++; if (bus.inta !== 1'b0) begin failures++; $display("FAIL rel_inta got=%0h exp=0", bus.inta); end
        bus.irq = 4'h0;
        step();
        $display("test_reset: done");
    endtask

    task automatic test_syscall();
        bus.sta = 32'h3; bus.op = 6'h00; bus.funct = 6'h0C; bus.pc_in = 32'h0040_0010;
        step();
        checks++; if (bus.pcint !== 1'b1) begin failures++; $display("FAIL sys_pcint got=%0h exp=1", bus.pcint); end
        checks++; if (bus.cause !== 4'b0100) begin failures++; $display("FAIL sys_cause got=%0h exp=4", bus.cause); end
        checks++; if (bus.irq_id !== 3'd0) begin failures++; $display("FAIL sys_irq_id got=%0h exp=0", bus.irq_id); end
        checks++; if (bus.epc !== 32'h0040_0010) begin failures++; $display("FAIL sys_epc got=%0h exp=00400010", bus.epc); end
        checks++; if (bus.inta !== 1'b1) begin failures++; $display("FAIL sys_inta got=%0h exp=1", bus.inta); end
        bus.funct = 6'h00;
        step();
        checks++; if (bus.pcint !== 1'b0) begin failures++; $display("FAIL sys_pcint_once got=%0h exp=0", bus.pcint); end
        checks++; if (bus.inta !== 1'b1) begin failures++; $display("FAIL sys_inta_hold got=%0h exp=1", bus.inta); end
        bus.eret = 1'b1;
        step();
        checks++; if (bus.inta !== 1'b0) begin failures++; $display("FAIL sys_eret_inta got=%0h exp=0", bus.inta); end
        checks++; if (bus.cause !== 4'b0100) begin failures++; $display("FAIL sys_eret_cause got=%0h exp=4", bus.cause); end
        checks++; if (bus.epc !== 32'h0040_0010) begin failures++; $display("FAIL sys_eret_epc got=%0h exp=00400010", bus.epc); end
        // eret while already idle changes nothing
        step();
        bus.eret = 1'b0;
        checks++; if (bus.inta !== 1'b0 || bus.pcint !== 1'b0) begin failures++; $display("FAIL eret_idle got=%0h%0h exp=00", bus.inta, bus.pcint); end
        step();
        $display("test_syscall: done");
    endtask

    task automatic test_priority();
        bus.sta = 32'h0000_0F07; bus.irq = 4'b1010; bus.funct = 6'h0D; bus.pc_in = 32'h100;
        step();
        checks++; if (bus.pcint !== 1'b1) begin failures++; $display("FAIL pri_brk_pcint got=%0h exp=1", bus.pcint); end
        checks++; if (bus.cause !== 4'b1000) begin failures++; $display("FAIL pri_brk_cause got=%0h exp=8", bus.cause); end
        checks++; if (bus.epc !== 32'h100) begin failures++; $display("FAIL pri_brk_epc got=%0h exp=100", bus.epc); end
        checks++; if (bus.pending !== 4'b1010) begin failures++; $display("FAIL pri_pending got=%0h exp=a", bus.pending); end
        bus.funct = 6'h00; bus.irq = 4'b0000;
        step();
        bus.eret = 1'b1; bus.pc_in = 32'h200;
        step();
        bus.eret = 1'b0;
        step();
        checks++; if (bus.pcint !== 1'b1) begin failures++; $display("FAIL pri_irq1_pcint got=%0h exp=1", bus.pcint); end
        checks++; if (bus.irq_id !== 3'd1) begin failures++; $display("FAIL pri_irq1_id got=%0h exp=1", bus.irq_id); end
        checks++; if (bus.cause !== 4'b0000) begin failures++; $display("FAIL pri_irq1_cause got=%0h exp=0", bus.cause); end
        checks++; if (bus.epc !== 32'h200) begin failures++; $display("FAIL pri_irq1_epc got=%0h exp=200", bus.epc); end
        checks++; if (bus.pending !== 4'b1000) begin failures++; $display("FAIL pri_irq1_pending got=%0h exp=8", bus.pending); end
        bus.eret = 1'b1; bus.pc_in = 32'h300;
        step();
        bus.eret = 1'b0;
        step();
        checks++; if (bus.pcint !== 1'b1) begin failures++; $display("FAIL pri_irq3_pcint got=%0h exp=1", bus.pcint); end
        checks++; if (bus.irq_id !== 3'd3) begin failures++; $display("FAIL pri_irq3_id got=%0h exp=3", bus.irq_id); end
        checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL pri_irq3_pending got=%0h exp=0", bus.pending); end
        finish_service();
        $display("test_priority: done");
    endtask

    task automatic test_masking();
        bus.sta = 32'h0000_0400; bus.irq = 4'b0100;
        step();
        bus.irq = 4'b0000;
        step(4);
        checks++; if (bus.pending !== 4'b0100) begin failures++; $display("FAIL mask_pending got=%0h exp=4", bus.pending); end
        checks++; if (bus.pcint !== 1'b0 || bus.inta !== 1'b0) begin failures++; $display("FAIL mask_no_take got=%0h%0h exp=00", bus.pcint, bus.inta); end
        bus.sta = 32'h0000_0401; bus.pc_in = 32'h400;
        step();
        checks++; if (bus.pcint !== 1'b1) begin failures++; $display("FAIL mask_en_pcint got=%0h exp=1", bus.pcint); end
        checks++; if (bus.irq_id !== 3'd2) begin failures++; $display("FAIL mask_en_id got=%0h exp=2", bus.irq_id); end
        checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL mask_en_pending got=%0h exp=0", bus.pending); end
        finish_service();
        $display("test_masking: done");
    endtask

    task automatic test_no_nesting();
        bus.sta = 32'h0000_0107; bus.funct = 6'h0C; bus.pc_in = 32'h500;
        step();
        bus.funct = 6'h00;
        step();
        bus.irq = 4'b0001; bus.funct = 6'h0C;
        step();
        checks++; if (bus.pcint !== 1'b0) begin failures++; $display("FAIL nest_pcint got=%0h exp=0", bus.pcint); end
        checks++; if (bus.pending !== 4'b0001) begin failures++; $display("FAIL nest_pending got=%0h exp=1", bus.pending); end
        checks++; if (bus.cause !== 4'b0100) begin failures++; $display("FAIL nest_cause got=%0h exp=4", bus.cause); end
        bus.irq = 4'b0000; bus.funct = 6'h00; bus.eret = 1'b1;
        step();
        checks++; if (bus.inta !== 1'b0) begin failures++; $display("FAIL nest_eret_inta got=%0h exp=0", bus.inta); end
        bus.eret = 1'b0; bus.pc_in = 32'h600;
        step();
        checks++; if (bus.pcint !== 1'b1) begin failures++; $display("FAIL nest_irq0_pcint got=%0h exp=1", bus.pcint); end
        checks++; if (bus.cause !== 4'b0000 || bus.irq_id !== 3'd0) begin failures++; $display("FAIL nest_irq0_cause_id got=%0h/%0h exp=0/0", bus.cause, bus.irq_id); end
        checks++; if (bus.epc !== 32'h600) begin failures++; $display("FAIL nest_irq0_epc got=%0h exp=600", bus.epc); end
        finish_service();
        checks++; if (bus.pcint !== 1'b0 || bus.inta !== 1'b0) begin failures++; $display("FAIL nest_no_replay got=%0h%0h exp=00", bus.pcint, bus.inta); end
        $display("test_no_nesting: done");
    endtask

    task automatic test_collision();
        bus.sta = 32'h0000_0100; bus.irq = 4'b0001;
        step();
        bus.irq = 4'b0000;
        step(2);
        // new edge on line 0 arrives in the same cycle line 0 is taken
        bus.irq = 4'b0001; bus.sta = 32'h0000_0101;
        step();
        checks++; if (bus.pcint !== 1'b1 || bus.irq_id !== 3'd0) begin failures++; $display("FAIL coll_take got=%0h/%0h exp=1/0", bus.pcint, bus.irq_id); end
        checks++; if (bus.pending !== 4'b0001) begin failures++; $display("FAIL coll_pending got=%0h exp=1", bus.pending); end
        bus.irq = 4'b0000;
        step();
        finish_service();
        checks++; if (bus.pcint !== 1'b1 || bus.pending !== 4'b0000) begin failures++; $display("FAIL coll_retake got=%0h/%0h exp=1/0", bus.pcint, bus.pending); end
        finish_service();
        $display("test_collision: done");
    endtask

    task automatic test_back_to_back();
        bus.sta = 32'h0000_0201; bus.irq = 4'b0010;
        step();
        checks++; if (bus.pcint !== 1'b0 || bus.pending !== 4'b0010) begin failures++; $display("FAIL lat_k got=%0h/%0h exp=0/2", bus.pcint, bus.pending); end
        step();
        checks++; if (bus.pcint !== 1'b1 || bus.irq_id !== 3'd1) begin failures++; $display("FAIL lat_k1 got=%0h/%0h exp=1/1", bus.pcint, bus.irq_id); end
        // two edges on line 1 during service merge into one pending bit
        bus.irq = 4'b0000; step();
        bus.irq = 4'b0010; step();
        bus.irq = 4'b0000; step();
        bus.irq = 4'b0010; step();
        bus.irq = 4'b0000; step();
        checks++; if (bus.pending !== 4'b0010 || bus.inta !== 1'b1) begin failures++; $display("FAIL merge_pending got=%0h/%0h exp=2/1", bus.pending, bus.inta); end
        finish_service();
        checks++; if (bus.pcint !== 1'b1 || bus.pending !== 4'b0000) begin failures++; $display("FAIL merge_take got=%0h/%0h exp=1/0", bus.pcint, bus.pending); end
        finish_service();
        checks++; if (bus.pcint !== 1'b0 || bus.inta !== 1'b0) begin failures++; $display("FAIL merge_single got=%0h%0h exp=00", bus.pcint, bus.inta); end
        $display("test_back_to_back: done");
    endtask

    task automatic test_async_reset();
        bus.sta = 32'h0000_0107; bus.funct = 6'h0C; bus.pc_in = 32'h700;
        step();
        bus.funct = 6'h00; bus.irq = 4'b0100;
        step();
        checks++; if (bus.inta !== 1'b1 || bus.pending !== 4'b0100) begin failures++; $display("FAIL ar_pre got=%0h/%0h exp=1/4", bus.inta, bus.pending); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.inta !== 1'b0) begin failures++; $display("FAIL ar_inta got=%0h exp=0", bus.inta); end
        checks++; if (bus.epc !== 32'h0) begin failures++; $display("FAIL ar_epc got=%0h exp=0", bus.epc); end
        checks++; if (bus.pending !== 4'h0) begin failures++; $display("FAIL ar_pending got=%0h exp=0", bus.pending); end
        checks++; if (bus.cause !== 4'h0) begin failures++; $display("FAIL ar_cause got=%0h exp=0", bus.cause); end
        step();
        rst = 1'b0;
        step(2);
        checks++; if (bus.pending !== 4'h0 || bus.inta !== 1'b0) begin failures++; $display("FAIL ar_post got=%0h/%0h exp=0/0", bus.pending, bus.inta); end
        bus.irq = 4'b0000;
        step();
        $display("test_async_reset: done");
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_priority();
        test_masking();
        test_no_nesting();
        test_collision();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Parametrised interrupt/exception controller for the multi-cycle MIPS CPU.
- Combines synchronous exceptions decoded from op/funct (syscall, break) with N_IRQ edge-triggered external interrupt lines.
- Sources are gated by status-register enables and resolved by fixed priority.
- Produces a registered one-cycle PC-redirect pulse, cause code, interrupt id and captured EPC; tracks in-service state until eret, with no nesting.

Parameters:
N_IRQ, 4, number of external interrupt lines (1..8)
PC_W, 32, width of pc_in/epc
CAUSE_W, 4, width of cause output

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
irq  input  N_IRQ  external interrupt lines, rising-edge triggered, synchronous to clk
op  input  6  opcode of current instruction
funct  input  6  funct field of current instruction
sta  input  32  status register: [0] global IE, [1] syscall enable, [2] break enable, [8+i] irq i enable
pc_in  input  PC_W  PC of current instruction
eret  input  1  return-from-exception strobe, one cycle
inta  output  1  in-service flag (high from take until eret)
pcint  output  1  one-cycle redirect pulse to exception vector
cause  output  CAUSE_W  cause code of taken event
irq_id  output  3  index of taken external line (0 for sync exceptions)
epc  output  PC_W  PC captured at take
pending  output  N_IRQ  latched pending external requests

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; inta=0, pcint=0, cause=0, irq_id=0, epc=0, pending=0.
  - Edge-detect register irq_d set to all ones, so a line already high at reset release does not count as an edge.
- Edge detect: irq_d<=irq each cycle; edge[i]=irq[i]&~irq_d[i].
- Pending: pending[i] sets on edge[i]. Cleared when line i is taken. Set wins over clear in the same cycle. Pending sets in every state, including IN_SVC.
- Sync requests (combinational):
  - sys_req = op==0 && funct==6'h0C && sta[1].
  - brk_req = op==0 && funct==6'h0D && sta[2].
- External request: ext_req[i] = pending[i] && sta[8+i].
- Priority: sys_req > brk_req > ext_req[0] > ext_req[1] > ... > ext_req[N_IRQ-1].
- Global IE: sta[0] gates external requests only. Syscall/break are taken whenever their own enable is set.
- FSM, states IDLE and IN_SVC:
  - IDLE, any eligible request at a clock edge:
    - state->IN_SVC; inta<=1; pcint<=1 for exactly one cycle; epc<=pc_in.
    - cause<=4'b0100 (syscall), 4'b1000 (break) or 4'b0000 (external).
    - irq_id<=winning index (0 for sync).
    - The winning pending bit clears at the same edge.
  - IDLE, no request: outputs hold; pcint=0.
  - IN_SVC:
    - All new requests are blocked; sync requests are dropped; external requests stay pending.
    - eret=1 -> state->IDLE, inta<=0. cause, irq_id and epc hold their values.
    - A request present in the cycle after eret is taken normally, giving a minimum 1 idle cycle between services.
  - eret in IDLE: ignored.
- Latency:
  - External: irq rises before edge k -> pending at edge k -> taken at edge k+1 (pcint high in cycle k+1..k+2), given IDLE and enabled.
  - Sync: op/funct valid before edge k -> pcint high after edge k.
- Masked pending (sta[8+i]=0 or sta[0]=0): remains pending indefinitely and is taken when re-enabled.
- Repeated edge on an already pending line: merges (no count).
- Reset mid-service: immediate return to reset values; pending lost.

Test Plan:
- Syscall: sta=0x3, op=0, funct=0x0C, pc_in=0x00400010 -> next cycle pcint=1 (one cycle), cause=0100, irq_id=0, epc=0x00400010, inta=1 until eret.
- Priority: sta=0x0F07, irq=4'b1010 edge together with break instr -> break taken (cause=1000). After eret, irq1 taken (irq_id=1). After second eret, irq3 taken.
- Masking: sta[0]=0, irq2 pulse -> pending=0100, no pcint. Set sta=0x0401 -> pcint 1 cycle later, irq_id=2, pending=0.
- No nesting: in IN_SVC, irq0 pulse and syscall -> no pcint, pending[0]=1. eret -> IDLE, next cycle pcint with irq_id=0; syscall not replayed.
- Set/clear collision: irq0 taken in the same cycle as a new irq0 edge -> pending[0] remains 1 after take.
- Reset: irq held high through rst deassert -> no pending. Assert rst during IN_SVC -> inta=0, epc=0, pending=0 immediately (asynchronously).
